axil_bram_slave: RTL and testbench
==================================

AXIL_BRAM_SLAVE -- requirements
Module: axil_bram_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI data and memory word width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI byte-address width in bits.
REQ-003 SHALL have parameter RAM_DEPTH, default 256, number of words; power of two, at least 2.
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have: s00_axi_awaddr in ADDR_WIDTH; s00_axi_awprot in 3 (ignored); s00_axi_awvalid in 1; s00_axi_awready out 1.
REQ-007 SHALL have: s00_axi_wdata in DATA_WIDTH; s00_axi_wstrb in DATA_WIDTH/8; s00_axi_wvalid in 1; s00_axi_wready out 1.
REQ-008 SHALL have: s00_axi_bresp out 2; s00_axi_bvalid out 1; s00_axi_bready in 1.
REQ-009 SHALL have: s00_axi_araddr in ADDR_WIDTH; s00_axi_arprot in 3 (ignored); s00_axi_arvalid in 1; s00_axi_arready out 1.
REQ-010 SHALL have: s00_axi_rdata out DATA_WIDTH; s00_axi_rresp out 2; s00_axi_rvalid out 1; s00_axi_rready in 1.

Function
REQ-011 SHALL contain an internal simple-dual-port memory of RAM_DEPTH x DATA_WIDTH, one write port, one synchronous read port with 1-cycle latency, read-first on same-word collision.
REQ-012 SHALL compute the word index as addr[LSB +: log2(RAM_DEPTH)], with LSB = log2(DATA_WIDTH/8); low LSB address bits are ignored.
REQ-013 SHALL run a write FSM W_IDLE -> W_ACK -> W_RESP -> W_IDLE, with all handshake outputs registered.
REQ-014 SHALL, in W_IDLE, move to W_ACK only when awvalid and wvalid are both high in the same cycle; awvalid or wvalid alone SHALL NOT advance the FSM.
REQ-015 SHALL, in W_ACK, hold awready = wready = 1 for exactly one cycle, then at that edge write each byte lane i whose wstrb[i] = 1; lanes with wstrb[i] = 0 SHALL be unchanged.
REQ-016 SHALL, in W_RESP, hold bvalid = 1 and a stable bresp until bready = 1, then return to W_IDLE on that edge.
REQ-017 SHALL run a read FSM R_IDLE -> R_ACK -> R_READ -> R_DATA -> R_IDLE, independent of the write FSM.
REQ-018 SHALL, in R_ACK, hold arready = 1 for one cycle and latch araddr.
REQ-019 SHALL, in R_READ, issue the memory read.
REQ-020 SHALL, on entry to R_DATA, capture the read data into the rdata register.
REQ-021 SHALL, in R_DATA, hold rvalid = 1 and stable rdata/rresp until rready = 1, then return to R_IDLE.
REQ-022 SHALL meet these latencies: arready high 1 cycle after arvalid is first sampled in R_IDLE; rvalid high 3 cycles after; bvalid high 2 cycles after awvalid&&wvalid is first sampled in W_IDLE.
REQ-023 SHALL service a read and a write concurrently; if the W_ACK write edge coincides with the R_READ edge on the same word, rdata SHALL be the pre-write value.
REQ-024 SHALL accept back-to-back transactions, with a new request sampled in the IDLE cycle after completion; throughput is at most 1 write per 3 cycles and 1 read per 4 cycles.

Reset
REQ-025 SHALL, while reset = 1, force both FSMs to IDLE and set awready, wready, bvalid, arready and rvalid to 0, and bresp, rresp and rdata to 0, asynchronously.
REQ-026 SHALL abort any in-flight transaction on reset with no response; a write whose W_ACK edge has not occurred SHALL NOT modify memory.
REQ-027 SHALL NOT clear memory contents on reset; contents SHALL be retained across reset and are undefined after power-up.

Configuration
REQ-028 SHALL, when macro AXIL_BRAM_SLAVE_BOUNDS_CHECK_EN is defined, treat any address >= RAM_DEPTH*(DATA_WIDTH/8) as out of range.
REQ-029 SHALL, for an out-of-range write with the macro defined, suppress the memory write and return bresp = 2'b10 (SLVERR).
REQ-030 SHALL, for an out-of-range read with the macro defined, return rdata = 0 and rresp = 2'b10; in-range accesses SHALL return 2'b00.
REQ-031 SHALL, when the macro is undefined, ignore upper address bits (addresses alias and wrap modulo the memory size) and always return bresp = rresp = 2'b00.

Verification
REQ-032 SHALL cover: write 0x0000_0010 data 0xDEADBEEF strb 0xF, then read 0x10 -> bresp 0, rdata 0xDEADBEEF, rresp 0, rvalid 3 cycles after arvalid.
REQ-033 SHALL cover: preload 0x11223344 at 0x20, write 0xAABBCCDD with strb 0x5, then read 0x20 -> 0x11BB33DD.
REQ-034 SHALL cover: hold bready = 0 for 5 cycles and rready = 0 for 5 cycles -> bvalid/rvalid stay 1, bresp/rdata stable throughout, FSMs then return to IDLE.
REQ-035 SHALL cover: write 0x400 data 0x1 (DEPTH 256, 32-bit) -> with macro: bresp 2'b10, word 0 unchanged; without macro: word 0 = 0x1, bresp 0.
REQ-036 SHALL cover: assert reset during W_RESP and during R_READ -> all valids/readies 0 immediately, no response after release, next write/read completes normally.
REQ-037 SHALL cover: awvalid held 4 cycles with wvalid = 0, then wvalid = 1 -> awready stays 0 until the cycle after both are high.

Source files
------------

// File: rtl/axil_bram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axil_bram_slave
//  Purpose  : AXI4-Lite slave fronting an internal simple-dual-port block RAM
//             (RAM_DEPTH words of DATA_WIDTH bits). Independent write and read
//             state machines; every handshake output is a flop.
//
//  Ports    : clk                 - single clock, rising edge
//             reset               - asynchronous, active-high
//             s00_axi_aw*         - write address channel (awprot ignored)
//             s00_axi_w*          - write data channel with byte strobes
//             s00_axi_b*          - write response channel
//             s00_axi_ar*         - read address channel (arprot ignored)
//             s00_axi_r*          - read data channel
//
//  Build    : define AXIL_BRAM_SLAVE_BOUNDS_CHECK_EN to flag accesses at or
//             beyond RAM_DEPTH*(DATA_WIDTH/8) with SLVERR (writes dropped,
//             reads return zero). Without it, upper address bits alias.
//
//  Revision : 1.0 - initial release
// ============================================================================
module axil_bram_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RAM_DEPTH  = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    // write address
    input  logic [ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]              s00_axi_awprot,
    input  logic                    s00_axi_awvalid,
    output logic                    s00_axi_awready,
    // write data
    input  logic [DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                    s00_axi_wvalid,
    output logic                    s00_axi_wready,
    // write response
    output logic [1:0]              s00_axi_bresp,
    output logic                    s00_axi_bvalid,
    input  logic                    s00_axi_bready,
    // read address
    input  logic [ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]              s00_axi_arprot,
    input  logic                    s00_axi_arvalid,
    output logic                    s00_axi_arready,
    // read data
    output logic [DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]              s00_axi_rresp,
    output logic                    s00_axi_rvalid,
    input  logic                    s00_axi_rready
);

    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_LSB    = $clog2(c_STRB_W);
    localparam int c_IDX_W  = $clog2(RAM_DEPTH);
    localparam int c_HI     = c_LSB + c_IDX_W;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_ACK  = 2'd1;
    localparam logic [1:0] c_W_RESP = 2'd2;

    localparam logic [1:0] c_R_IDLE = 2'd0;
    localparam logic [1:0] c_R_ACK  = 2'd1;
    localparam logic [1:0] c_R_READ = 2'd2;
    localparam logic [1:0] c_R_DATA = 2'd3;

    // ------------------------------------------------------------------
    // Storage and address decode
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

    logic [c_IDX_W-1:0]    w_aw_idx;
    logic [c_IDX_W-1:0]    w_ar_idx;
    logic                  w_aw_oob;
    logic                  w_ar_oob;

    assign w_aw_idx = s00_axi_awaddr[c_LSB +: c_IDX_W];
    assign w_ar_idx = s00_axi_araddr[c_LSB +: c_IDX_W];

`ifdef AXIL_BRAM_SLAVE_BOUNDS_CHECK_EN
    // Any set bit above the word index means the byte address is past the end.
    assign w_aw_oob = (s00_axi_awaddr >> c_HI) != '0;
    assign w_ar_oob = (s00_axi_araddr >> c_HI) != '0;
`else
    assign w_aw_oob = 1'b0;
    assign w_ar_oob = 1'b0;
`endif

    // Protection bits, sub-word offset and (when aliasing) upper address bits
    // carry no meaning for this slave.
    logic w_unused_ok;
    assign w_unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr, s00_axi_araddr};

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    logic [1:0] r_wstate;
    logic [1:0] w_wstate_nxt;
    logic       r_awready;
    logic       r_wready;
    logic       r_bvalid;
    logic [1:0] r_bresp;
    logic       w_awready_d;
    logic       w_bvalid_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wstate  <= c_W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= w_awready_d;
            r_wready  <= w_awready_d;
            r_bvalid  <= w_bvalid_d;
            // Response is decided on the handshake edge and then frozen.
            if (r_wstate == c_W_ACK) begin
                r_bresp <= w_aw_oob ? c_RESP_SLVERR : c_RESP_OKAY;
            end
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            c_W_IDLE: if (s00_axi_awvalid && s00_axi_wvalid) w_wstate_nxt = c_W_ACK;
            c_W_ACK:  w_wstate_nxt = c_W_RESP;  // ready is high, master is holding valid
            c_W_RESP: if (s00_axi_bready) w_wstate_nxt = c_W_IDLE;
            default:  w_wstate_nxt = c_W_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the flops mirror the state.
    always_comb begin
        w_awready_d = (w_wstate_nxt == c_W_ACK);
        w_bvalid_d  = (w_wstate_nxt == c_W_RESP);
    end

    // Memory write happens on the W_ACK handshake edge. Reset forces the FSM
    // out of W_ACK asynchronously, so an aborted write never lands.
    logic w_mem_we;
    assign w_mem_we = (r_wstate == c_W_ACK) && !w_aw_oob;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < c_STRB_W; i++) begin
                if (s00_axi_wstrb[i]) begin
                    r_mem[w_aw_idx][8*i +: 8] <= s00_axi_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    logic [1:0]            r_rstate;
    logic [1:0]            w_rstate_nxt;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_arready_d;
    logic                  w_rvalid_d;
    logic [c_IDX_W-1:0]    r_ar_idx;
    logic                  r_ar_oob;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rstate  <= c_R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= c_RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= w_arready_d;
            r_rvalid  <= w_rvalid_d;
            // The read-port register doubles as the rdata register; a
            // non-blocking read of the array gives read-first behaviour
            // against a same-edge write.
            if (r_rstate == c_R_READ) begin
                r_rdata <= r_ar_oob ? '0 : r_mem[r_ar_idx];
                r_rresp <= r_ar_oob ? c_RESP_SLVERR : c_RESP_OKAY;
            end
        end
    end

    // Address is captured on the arready handshake edge.
    always_ff @(posedge clk) begin
        if (r_rstate == c_R_ACK) begin
            r_ar_idx <= w_ar_idx;
            r_ar_oob <= w_ar_oob;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            c_R_IDLE: if (s00_axi_arvalid) w_rstate_nxt = c_R_ACK;
            c_R_ACK:  w_rstate_nxt = c_R_READ;
            c_R_READ: w_rstate_nxt = c_R_DATA;
            c_R_DATA: if (s00_axi_rready) w_rstate_nxt = c_R_IDLE;
            default:  w_rstate_nxt = c_R_IDLE;
        endcase
    end

    always_comb begin
        w_arready_d = (w_rstate_nxt == c_R_ACK);
        w_rvalid_d  = (w_rstate_nxt == c_R_DATA);
    end

    // ------------------------------------------------------------------
    // Port drivers
    // ------------------------------------------------------------------
    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_wready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = r_bresp;
    assign s00_axi_arready = r_arready;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rresp   = r_rresp;
    assign s00_axi_rdata   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_axil_bram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_bram_slave
//  Purpose  : Self-checking bench for axil_bram_slave (32-bit, 256 words).
//             Directed vector table, hand-written corner sequences and a
//             randomized phase checked against a byte-masked memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axil_bram_slave;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 256;

`ifdef AXIL_BRAM_SLAVE_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    always #5 clk = ~clk;

    axil_bram_slave #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RAM_DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a clock edge. hold = cycles bready stays low with bvalid up.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int hold,
                             output logic [1:0] resp);
        int n;
        logic [1:0] r0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 16);
        check("aw_latency", n, 1);
        check("wready_in_ack", wready, 1);
        @(posedge clk); #1; n++;
        awvalid = 1'b0; wvalid = 1'b0;
        check("awready_one_cycle", awready, 0);
        while (!bvalid && n < 16) begin @(posedge clk); #1; n++; end
        check("b_latency", n, 2);
        r0 = bresp;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("bvalid_hold", bvalid, 1);
            check("bresp_stable", bresp, r0);
        end
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bvalid_clear", bvalid, 0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        logic [31:0] d0;
        logic [1:0]  r0;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!arready && n < 16);
        check("ar_latency", n, 1);
        @(posedge clk); #1; n++;
        arvalid = 1'b0;
        check("arready_one_cycle", arready, 0);
        while (!rvalid && n < 16) begin @(posedge clk); #1; n++; end
        check("r_latency", n, 3);
        d0 = rdata; r0 = rresp;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("rvalid_hold", rvalid, 1);
            check("rdata_stable", rdata, d0);
            check("rresp_stable", rresp, r0);
        end
        data = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_clear", rvalid, 0);
    endtask

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[13];

    // Reference model: word contents plus a mask of bytes the bench has written.
    logic [31:0] mdl      [DEPTH];
    logic [31:0] mdl_mask [DEPTH];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          widx;
        bit          in_range;
        logic [1:0]  exp_resp;

        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        2'b00};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
        vecs[2]  = '{1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        2'b00};
        vecs[3]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0,        2'b00};
        vecs[4]  = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 2'b00};
        vecs[5]  = '{1'b0, 32'h23,  32'h0,        4'h0, 32'h11BB33DD, 2'b00};
        vecs[6]  = '{1'b1, 32'h10,  32'h12345678, 4'hA, 32'h0,        2'b00};
        vecs[7]  = '{1'b0, 32'h11,  32'h0,        4'h0, 32'h12AD56EF, 2'b00};
        vecs[8]  = '{1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0,        2'b00};
        vecs[9]  = '{1'b1, 32'h3FC, 32'hFFFFFFFF, 4'h0, 32'h0,        2'b00};
        vecs[10] = '{1'b0, 32'h3FE, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00};
        vecs[11] = '{1'b1, 32'h14,  32'h00FF00FF, 4'hF, 32'h0,        2'b00};
        vecs[12] = '{1'b0, 32'h14,  32'h0,        4'h0, 32'h00FF00FF, 2'b00};

        for (int i = 0; i < DEPTH; i++) begin
            mdl[i] = '0;
            mdl_mask[i] = '0;
        end

        reset = 1'b1;
        awaddr = '0; awprot = 3'b0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = 3'b0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_handshakes", {awready, wready, bvalid, arready, rvalid}, 0);
        check("reset_resps", {bresp, rresp}, 0);
        check("reset_rdata", rdata, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // ---------------- vector table ----------------
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_write) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, resp);
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, 0, rd, resp);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
            end
        end

        // ---------------- backpressure on both response channels ----------------
        axi_write(32'h80, 32'h5A5A5A5A, 4'hF, 5, resp);
        check("bp_bresp", resp, 0);
        axi_read(32'h80, 5, rd, resp);
        check("bp_rdata", rd, 32'h5A5A5A5A);

        // ---------------- out-of-range / aliasing ----------------
        axi_write(32'h0, 32'h55, 4'hF, 0, resp);
        axi_write(32'h400, 32'h1, 4'hF, 0, resp);
        check("oob_bresp", resp, BOUNDS ? 2'b10 : 2'b00);
        axi_read(32'h0, 0, rd, resp);
        check("oob_word0", rd, BOUNDS ? 32'h55 : 32'h1);
        axi_read(32'h400, 0, rd, resp);
        check("oob_rdata", rd, BOUNDS ? 32'h0 : 32'h1);
        check("oob_rresp", resp, BOUNDS ? 2'b10 : 2'b00);

        // ---------------- same-word collision: read must see old value ----------------
        axi_write(32'h40, 32'h01020304, 4'hF, 0, resp);
        fork
            begin
                logic [31:0] crd;
                logic [1:0]  crs;
                axi_read(32'h40, 0, crd, crs);
                check("collide_read_first", crd, 32'h01020304);
            end
            begin
                logic [1:0] cws;
                @(posedge clk); #1;
                axi_write(32'h40, 32'hF0E0D0C0, 4'hF, 0, cws);
                check("collide_bresp", cws, 0);
            end
        join
        axi_read(32'h40, 0, rd, resp);
        check("collide_after", rd, 32'hF0E0D0C0);

        // ---------------- awvalid alone does not advance ----------------
        awaddr = 32'h70; wdata = 32'h0000BEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("aw_only_awready", awready, 0);
            check("aw_only_wready", wready, 0);
        end
        wvalid = 1'b1;
        @(posedge clk); #1;
        check("aw_w_awready", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("aw_w_bvalid", bvalid, 1);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        axi_read(32'h70, 0, rd, resp);
        check("aw_w_rdata", rd, 32'h0000BEEF);

        // ---------------- reset during W_RESP ----------------
        awaddr = 32'h50; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 16);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("rstw_bvalid_pre", bvalid, 1);
        reset = 1'b1; #1;
        check("rstw_outputs", {awready, wready, bvalid, arready, rvalid, bresp, rresp}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("rstw_no_resp", bvalid, 0);
        end
        axi_write(32'h50, 32'h66, 4'hF, 0, resp);
        check("rstw_next_bresp", resp, 0);
        axi_read(32'h50, 0, rd, resp);
        check("rstw_next_rdata", rd, 32'h66);

        // ---------------- reset during R_READ ----------------
        araddr = 32'h50; arvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!arready && n < 16);
        @(posedge clk); #1;
        arvalid = 1'b0;
        reset = 1'b1; #1;
        check("rstr_outputs", {awready, wready, bvalid, arready, rvalid}, 0);
        check("rstr_rdata", rdata, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("rstr_no_resp", rvalid, 0);
        end
        axi_read(32'h50, 0, rd, resp);
        check("rstr_next_rdata", rd, 32'h66);

        // ---------------- reset in W_ACK: memory must be untouched ----------------
        axi_write(32'h60, 32'h13572468, 4'hF, 0, resp);
        awaddr = 32'h60; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 16);
        reset = 1'b1; #1;
        check("rsta_awready", awready, 0);
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        axi_read(32'h60, 0, rd, resp);
        check("rsta_mem_kept", rd, 32'h13572468);

        // ---------------- randomized traffic vs model ----------------
        for (int i = 0; i < 80; i++) begin
            addr = $urandom_range(0, 31) * 4 + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) addr = addr + 32'h400 * $urandom_range(1, 3);
            in_range = (addr < DEPTH * 4);
            widx     = int'((addr / 4) % DEPTH);
            exp_resp = (BOUNDS && !in_range) ? 2'b10 : 2'b00;
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                axi_write(addr, data, strb, $urandom_range(0, 2), resp);
                check("rnd_bresp", resp, exp_resp);
                if (!(BOUNDS && !in_range)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (strb[b]) begin
                            mdl[widx][8*b +: 8]      = data[8*b +: 8];
                            mdl_mask[widx][8*b +: 8] = 8'hFF;
                        end
                    end
                end
            end else begin
                axi_read(addr, $urandom_range(0, 2), rd, resp);
                check("rnd_rresp", resp, exp_resp);
                if (BOUNDS && !in_range) begin
                    check("rnd_rdata_oob", rd, 0);
                end else if (mdl_mask[widx] != 0) begin
                    check($sformatf("rnd_rdata_a%0h", addr), rd & mdl_mask[widx], mdl[widx] & mdl_mask[widx]);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
